// File: rtl/pokey_write_capture.sv
// Purpose: turns Atari 7800 CPU writes to the POKEY window into single register-write transactions.
// Latency: pin to synchronised copy 2 clk; push 2-3 clk after PHI2 falls; wr_valid the clk after.
// Backpressure: show-ahead FIFO drained by wr_valid/wr_ready; a push into a full FIFO is dropped and sets overflow.
module pokey_write_capture #(
  parameter logic [11:0] BASE_ADDR  = 12'h045,
  parameter int          FIFO_DEPTH = 4,
  parameter int          SETTLE     = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [15:0]                 a,
  input  logic [7:0]                  d_in,
  input  logic                        phi2,
  input  logic                        rw,
  input  logic                        halt,
  output logic                        wr_valid,
  output logic [3:0]                  wr_addr,
  output logic [7:0]                  wr_data,
  input  logic                        wr_ready,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  // SETTLE is left when the counter is about to reach SETTLE-1.
  localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE > 1) ? SETTLE - 2 : 0);
  localparam logic [LW-1:0] FULL_LEVEL  = LW'(FIFO_DEPTH);

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
    logic        phi2;
    logic        rw;
    logic        halt;
  } bus_t;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE
  } state_t;

  bus_t          bus_m_q, bus_m_d;
  bus_t          bus_s_q, bus_s_d;
  logic [1:0]    fill_q, fill_d;
  logic          p2_prev_q, p2_prev_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  entry_t        cand_q, cand_d;
  logic          cand_hit_q, cand_hit_d;
  entry_t        mem_q [FIFO_DEPTH];
  entry_t        mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;

  logic p2;
  logic p2_rise;
  logic hit;
  logic push_req;
  logic pop;
  logic full;
  logic push_ok;

  assign p2      = bus_s_q.phi2;
  assign p2_rise = p2 && !p2_prev_q;
  assign hit     = (bus_s_q.a[15:4] == BASE_ADDR) && !bus_s_q.rw && bus_s_q.halt;

  // Two-stage synchroniser; fill tracks when stage 2 holds real pin data again after reset,
  // and until then p2_prev is forced high so a PHI2 cycle already in progress is not seen as a rise.
  always_comb begin
    bus_m_d   = {a, d_in, phi2, rw, halt};
    bus_s_d   = bus_m_q;
    fill_d    = {fill_q[0], 1'b1};
    p2_prev_d = fill_q[1] ? p2 : 1'b1;
  end

  // Capture FSM: wait out the settle time, track the bus while PHI2 is high, commit on the fall.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cand_d     = cand_q;
    cand_hit_d = cand_hit_q;
    push_req   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (p2_rise) begin
          cnt_d      = '0;
          cand_hit_d = 1'b0;
          state_d    = (SETTLE > 1) ? ST_SETTLE : ST_SAMPLE;
        end
      end
      ST_SETTLE: begin
        if (!p2) begin
          state_d = ST_IDLE;
        end else if (cnt_q == SETTLE_LAST) begin
          cnt_d   = cnt_q + CW'(1);
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SAMPLE: begin
        if (p2) begin
          cand_d     = {bus_s_q.a[3:0], bus_s_q.d};
          cand_hit_d = hit;
        end else begin
          push_req = cand_hit_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Show-ahead FIFO; a pop in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    pop        = (level_q != '0) && wr_ready;
    full       = (level_q == FULL_LEVEL);
    push_ok    = push_req && (!full || pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q || (push_req && !push_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = cand_q;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // State register for synchroniser, FSM and FIFO with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_m_q    <= '0;
      bus_s_q    <= '0;
      fill_q     <= '0;
      p2_prev_q  <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cand_q     <= '0;
      cand_hit_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      bus_m_q    <= bus_m_d;
      bus_s_q    <= bus_s_d;
      fill_q     <= fill_d;
      p2_prev_q  <= p2_prev_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cand_q     <= cand_d;
      cand_hit_q <= cand_hit_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  assign wr_valid = (level_q != '0);
  assign wr_addr  = mem_q[rd_ptr_q].addr;
  assign wr_data  = mem_q[rd_ptr_q].data;
  assign level    = level_q;
  assign overflow = overflow_q;

endmodule
